and2_input_conditioner: RTL and testbench

//  Upstream stage for the AND2 gate: takes two asynchronous raw inputs (switches/pins), synchronises and

---
 rtl/and2_cond_pkg.sv | 21 ++
 rtl/and2_debounce_ch.sv | 102 ++++++++++
 rtl/and2_input_conditioner.sv | 80 ++++++++
 tb/tb_and2_input_conditioner.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/and2_cond_pkg.sv
// Shared types and constants for the AND2 input conditioner: channel FSM state
// encoding and the width/limit of the optional bounce statistics counter.
package and2_cond_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_COUNT = 1'b1
  } state_e;

  localparam int                  BOUNCE_W   = 16;
  localparam logic [BOUNCE_W-1:0] BOUNCE_MAX = '1;

  // Adds 0..2 aborts to the bounce count, clamping at BOUNCE_MAX instead of wrapping.
  function automatic logic [BOUNCE_W-1:0] sat_add(input logic [BOUNCE_W-1:0] base,
                                                  input logic [1:0]          inc);
    logic [BOUNCE_W:0] sum;
    sum = {1'b0, base} + {{(BOUNCE_W - 1){1'b0}}, inc};
    return sum[BOUNCE_W] ? BOUNCE_MAX : sum[BOUNCE_W-1:0];
  endfunction

endpackage

// File: rtl/and2_debounce_ch.sv
// One conditioner channel: a SYNC_STAGES-flop synchroniser feeding a two-state
// debounce FSM that commits a new level once it has held DEBOUNCE_CYCLES cycles.
module and2_debounce_ch
  import and2_cond_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic level_o,
  output logic chg_o,
  output logic idle_o,
  output logic abort_o
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced;
  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   chg_q, chg_d;
  logic                   abort;

  assign synced = sync_q[SYNC_STAGES-1];

  // Pure shift register: any logic between stages would let metastability leak through.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    chg_d   = 1'b0;
    abort   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (synced != level_q) begin
          if (DEBOUNCE_CYCLES == 1) begin
            level_d = synced;
            chg_d   = 1'b1;
          end else begin
            state_d = ST_COUNT;
            cnt_d   = CNT_ONE;
          end
        end
      end
      ST_COUNT: begin
        if (synced == level_q) begin
          // Input bounced back before the hold time elapsed: drop the attempt.
          state_d = ST_IDLE;
          cnt_d   = '0;
          abort   = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          level_d = synced;
          chg_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      level_q <= 1'b0;
      chg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      chg_q   <= chg_d;
    end
  end

  assign level_o = level_q;
  assign chg_o   = chg_q;
  assign idle_o  = (state_q == ST_IDLE);
  assign abort_o = abort;

endmodule

// File: rtl/and2_input_conditioner.sv
// Two-channel synchronise/debounce front end for the AND2 gate. Optional bounce
// statistics (STATS_CLR, BOUNCE_CNT) are built when AND2_COND_BOUNCE_STATS_EN is defined.
module and2_input_conditioner
  import and2_cond_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                CLK,
  input  logic                RSTN,
  input  logic                RAW0,
  input  logic                RAW1,
`ifdef AND2_COND_BOUNCE_STATS_EN
  input  logic                STATS_CLR,
  output logic [BOUNCE_W-1:0] BOUNCE_CNT,
`endif
  output logic                I0,
  output logic                I1,
  output logic                CHG0,
  output logic                CHG1,
  output logic                STABLE
);

  logic idle0, idle1;
  logic abort0, abort1;

  and2_debounce_ch #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_ch0 (
    .clk    (CLK),
    .rst_n  (RSTN),
    .raw_i  (RAW0),
    .level_o(I0),
    .chg_o  (CHG0),
    .idle_o (idle0),
    .abort_o(abort0)
  );

  and2_debounce_ch #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_ch1 (
    .clk    (CLK),
    .rst_n  (RSTN),
    .raw_i  (RAW1),
    .level_o(I1),
    .chg_o  (CHG1),
    .idle_o (idle1),
    .abort_o(abort1)
  );

  assign STABLE = idle0 & idle1;

`ifdef AND2_COND_BOUNCE_STATS_EN
  logic [BOUNCE_W-1:0] bounce_q, bounce_d;
  logic [1:0]          abort_sum;

  // Both channels may abort in the same cycle, so the increment is 0, 1 or 2.
  assign abort_sum = {1'b0, abort0} + {1'b0, abort1};

  always_comb begin
    bounce_d = STATS_CLR ? '0 : sat_add(bounce_q, abort_sum);
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      bounce_q <= '0;
    end else begin
      bounce_q <= bounce_d;
    end
  end

  assign BOUNCE_CNT = bounce_q;
`else
  logic unused_abort;
  assign unused_abort = abort0 ^ abort1;
`endif

endmodule

// File: tb/tb_and2_input_conditioner.sv
// Scoreboard bench for and2_input_conditioner (SYNC_STAGES=2, DEBOUNCE_CYCLES=4).
// Stats checks are compiled in when AND2_COND_BOUNCE_STATS_EN is defined.
module tb_and2_input_conditioner;
  import and2_cond_pkg::*;

  localparam int S   = 2;
  localparam int D   = 4;
  // RAW first sampled at edge e+1 -> synced after e+S -> FSM sees it for D edges -> commit at e+S+D.
  localparam int LAT = S + D;

  logic CLK = 1'b0;
  logic RSTN, RAW0, RAW1;
  logic I0, I1, CHG0, CHG1, STABLE;
`ifdef AND2_COND_BOUNCE_STATS_EN
  logic                STATS_CLR;
  logic [BOUNCE_W-1:0] BOUNCE_CNT;
`endif

  and2_input_conditioner #(
    .SYNC_STAGES    (S),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .CLK       (CLK),
    .RSTN      (RSTN),
    .RAW0      (RAW0),
    .RAW1      (RAW1),
`ifdef AND2_COND_BOUNCE_STATS_EN
    .STATS_CLR (STATS_CLR),
    .BOUNCE_CNT(BOUNCE_CNT),
`endif
    .I0        (I0),
    .I1        (I1),
    .CHG0      (CHG0),
    .CHG1      (CHG1),
    .STABLE    (STABLE)
  );

  always #5 CLK = ~CLK;

  int edge_cnt = 0;
  always @(posedge CLK) edge_cnt <= edge_cnt + 1;

  typedef struct {
    int   at_edge;
    logic chg0;
    logic chg1;
    logic i0;
    logic i1;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic lvl0, lvl1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic expect_event(input logic c0, input logic c1, input logic l0, input logic l1);
    exp_q.push_back('{edge_cnt + LAT, c0, c1, l0, l1});
  endtask

  // Monitor: any CHG pulse must match the oldest pending expected event.
  always @(negedge CLK) begin
    if (CHG0 || CHG1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_chg", {30'd0, CHG0, CHG1}, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("chg_edge", edge_cnt, mon_e.at_edge);
        check("chg_flags", {CHG0, CHG1}, {mon_e.chg0, mon_e.chg1});
        check("chg_levels", {I0, I1}, {mon_e.i0, mon_e.i1});
      end
    end
  end

  // Both raw inputs change together and hold; levels and STABLE are tracked every edge.
  task automatic clean_edge(input string name, input logic new0, input logic new1);
    logic old0, old1;
    old0 = lvl0;
    old1 = lvl1;
    RAW0 = new0;
    RAW1 = new1;
    expect_event(new0 != old0, new1 != old1, new0, new1);
    for (int k = 1; k <= LAT + 1; k++) begin
      tick(1);
      check({name, "_stable"}, STABLE, (k <= S || k >= LAT));
      check({name, "_level"}, {I0, I1}, (k >= LAT) ? {new0, new1} : {old0, old1});
    end
    lvl0 = new0;
    lvl1 = new1;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish, edge %0d", edge_cnt);
    $fatal(1, "watchdog expired");
  end

  initial begin
    RSTN = 1'b0;
    RAW0 = 1'b1;
    RAW1 = 1'b1;
`ifdef AND2_COND_BOUNCE_STATS_EN
    STATS_CLR = 1'b0;
`endif
    lvl0 = 1'b0;
    lvl1 = 1'b0;

    // Reset with both raw inputs high.
    tick(3);
    check("rst_levels", {I0, I1}, 2'b00);
    check("rst_chg", {CHG0, CHG1}, 2'b00);
    check("rst_stable", STABLE, 1'b1);
`ifdef AND2_COND_BOUNCE_STATS_EN
    check("rst_bounce", BOUNCE_CNT, 16'd0);
`endif
    RSTN = 1'b1;
    expect_event(1'b1, 1'b1, 1'b1, 1'b1);
    tick(LAT - 1);
    check("rel_pre_levels", {I0, I1}, 2'b00);
    tick(1);
    check("rel_levels", {I0, I1}, 2'b11);
    tick(1);
    check("rel_chg_low", {CHG0, CHG1}, 2'b00);
    lvl0 = 1'b1;
    lvl1 = 1'b1;

    // Clean fall on channel 0.
    clean_edge("fall0", 1'b0, 1'b1);

    // Bounce: RAW0 high for D-1 cycles then back low; must be suppressed.
    RAW0 = 1'b1;
    tick(D - 1);
    RAW0 = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick(1);
      check("bounce_level", I0, 1'b0);
    end
    check("bounce_stable", STABLE, 1'b1);
`ifdef AND2_COND_BOUNCE_STATS_EN
    check("bounce_cnt", BOUNCE_CNT, 16'd1);
`endif

    // Clean fall on channel 1, then a simultaneous rise on both.
    clean_edge("fall1", 1'b0, 1'b0);
    clean_edge("rise_both", 1'b1, 1'b1);

    // Reset mid-count: channel 1 counting a fall, reset after edge 3.
    RAW1 = 1'b0;
    tick(3);
    check("mid_stable", STABLE, 1'b0);
    RSTN = 1'b0;
    #1;
    check("mid_rst_levels", {I0, I1}, 2'b00);
    check("mid_rst_stable", STABLE, 1'b1);
`ifdef AND2_COND_BOUNCE_STATS_EN
    check("mid_rst_bounce", BOUNCE_CNT, 16'd0);
`endif
    tick(2);
    RSTN = 1'b1;
    expect_event(1'b1, 1'b0, 1'b1, 1'b0);
    tick(LAT - 1);
    check("mid_rel_pre", {I0, I1}, 2'b00);
    tick(1);
    check("mid_rel_levels", {I0, I1}, 2'b10);
    lvl0 = 1'b1;
    lvl1 = 1'b0;
    tick(2);

`ifdef AND2_COND_BOUNCE_STATS_EN
    // Toggle both inputs every cycle: both channels abort together every other edge.
    for (int i = 0; i < 66000; i++) begin
      RAW0 = i[0];
      RAW1 = ~i[0];
      tick(1);
    end
    RAW0 = lvl0;
    RAW1 = lvl1;
    tick(10);
    check("sat_bounce", BOUNCE_CNT, 16'hFFFF);
    check("sat_levels", {I0, I1}, {lvl0, lvl1});
    check("sat_stable", STABLE, 1'b1);
    STATS_CLR = 1'b1;
    tick(1);
    STATS_CLR = 1'b0;
    check("clr_bounce", BOUNCE_CNT, 16'd0);
    // Clear held across edges where aborts are occurring must still win.
    for (int i = 0; i < 8; i++) begin
      RAW0 = i[0];
      RAW1 = ~i[0];
      STATS_CLR = (i >= 4);
      tick(1);
      if (i >= 4) check("clr_priority", BOUNCE_CNT, 16'd0);
    end
    STATS_CLR = 1'b0;
    RAW0 = lvl0;
    RAW1 = lvl1;
    tick(10);
    check("post_levels", {I0, I1}, {lvl0, lvl1});
`endif

    tick(2);
    check("pending_events", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
